// File: rtl/seq_mul_16_pkg.sv
// Shared definitions for the sequential 16x16 multiplier: state encoding,
// iteration count and counter width.
package seq_mul_16_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int MUL_ITER = 16;
  localparam int CNT_W    = 4;
  localparam int ADD_W    = 16;

endpackage

// File: rtl/full_add_16.sv
// 16-bit two-level carry-lookahead adder: four 4-bit CLA groups whose group
// generate/propagate terms feed a second 4-bit lookahead stage.
module full_add_16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);

  // Carries c[1..4] of one 4-bit lookahead block; c[0] is the block carry-in.
  function automatic logic [4:0] cla4(input logic [3:0] g, input logic [3:0] p,
                                      input logic ci);
    logic [4:0] c;
    c[0] = ci;
    c[1] = g[0] | (p[0] & ci);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & ci);
    return c;
  endfunction

  logic [15:0] g_bit;
  logic [15:0] p_bit;
  logic [3:0]  g_grp;
  logic [3:0]  p_grp;
  logic [4:0]  c_grp;
  logic [15:0] c_bit;

  assign g_bit = a & b;
  assign p_bit = a ^ b;

  always_comb begin
    logic [4:0] c_tmp;
    g_grp = '0;
    p_grp = '0;
    for (int j = 0; j < 4; j++) begin
      c_tmp    = cla4(g_bit[4*j +: 4], p_bit[4*j +: 4], 1'b0);
      g_grp[j] = c_tmp[4];
      p_grp[j] = &p_bit[4*j +: 4];
    end
  end

  assign c_grp = cla4(g_grp, p_grp, cin);

  always_comb begin
    logic [4:0] c_tmp;
    c_bit = '0;
    for (int j = 0; j < 4; j++) begin
      c_tmp           = cla4(g_bit[4*j +: 4], p_bit[4*j +: 4], c_grp[j]);
      c_bit[4*j +: 4] = c_tmp[3:0];
    end
  end

  assign sum  = p_bit ^ c_bit;
  assign cout = c_grp[4];

endmodule

// File: rtl/seq_mul_16.sv
// Unsigned 16x16->32 shift-and-add multiplier with fixed 16-iteration latency.
// Each CALC cycle adds M (or 0) into the upper half and shifts the 17-bit sum right.
module seq_mul_16
  import seq_mul_16_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  // The iteration adder is a fixed 16-bit instance.
  if (WIDTH != ADD_W) begin : g_width_check
    $error("seq_mul_16: WIDTH must be 16");
  end

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   m_reg;
  logic [2*WIDTH-1:0] p_reg;
  logic [WIDTH-1:0]   add_b;
  logic [WIDTH-1:0]   add_s;
  logic               add_co;
  logic [2*WIDTH-1:0] p_shift;
  logic               last_iter;

  assign add_b = p_reg[0] ? m_reg : '0;

  full_add_16 u_add (
    .a    (p_reg[2*WIDTH-1:WIDTH]),
    .b    (add_b),
    .cin  (1'b0),
    .sum  (add_s),
    .cout (add_co)
  );

  // Carry-out lands in bit 31; dropping it would corrupt large products.
  assign p_shift   = {add_co, add_s, p_reg[WIDTH-1:1]};
  assign last_iter = (cnt == CNT_W'(MUL_ITER - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_CALC;
      ST_CALC: if (last_iter) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    ready = (state == ST_IDLE);
    busy  = (state == ST_CALC) || (state == ST_DONE);
    done  = (state == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      m_reg   <= '0;
      p_reg   <= '0;
      product <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            m_reg <= a;
            p_reg <= {{WIDTH{1'b0}}, b};
            cnt   <= '0;
          end
        end
        ST_CALC: begin
          p_reg <= p_shift;
          cnt   <= cnt + CNT_W'(1);
          // Publish on the last iteration so product is valid alongside done.
          if (last_iter) product <= p_shift;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mul_16.sv
// Self-checking bench for seq_mul_16: a timeline model of the handshake plus
// a*b arithmetic, checked every cycle, with directed and random operations.
module tb_seq_mul_16;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        ready;
  logic        busy;
  logic        done;
  logic [31:0] product;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit chk_en = 0;

  // Model: m_cnt is cycles since the accepting edge (-1 = idle).
  int          m_cnt  = -1;
  logic [31:0] m_pend = '0;
  logic [31:0] m_prod = '0;

  seq_mul_16 #(.WIDTH(16)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .ready   (ready),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    if (rst) begin
      m_cnt  = -1;
      m_prod = '0;
    end else if (m_cnt < 0) begin
      if (start) begin
        m_cnt  = 0;
        m_pend = 32'(a) * 32'(b);
      end
    end else begin
      m_cnt++;
      if (m_cnt == 16) m_prod = m_pend;
      if (m_cnt == 17) m_cnt = -1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("ready", 32'(ready), 32'(m_cnt < 0));
      chk("busy", 32'(busy), 32'(m_cnt >= 0));
      chk("done", 32'(done), 32'(m_cnt == 16));
      chk("product", product, m_prod);
    end
  end

  task automatic wait_ready();
    for (int i = 0; i < 40 && !ready; i++) @(negedge clk);
    if (!ready) chk("ready_timeout", 32'(ready), 32'd1);
  endtask

  // Starts one operation and waits for done; lat counts negedges from the
  // start cycle to the done cycle. inject pokes start during CALC and DONE.
  task automatic run_op(input logic [15:0] ia, input logic [15:0] ib, input bit inject,
                        output logic [31:0] p, output int lat, output int busy_cyc);
    bit found = 0;
    p = '0; lat = 0; busy_cyc = 0;
    wait_ready();
    start = 1; a = ia; b = ib;
    for (int k = 1; k <= 40 && !found; k++) begin
      @(negedge clk);
      if (k == 1) begin start = 0; a = 16'($urandom); b = 16'($urandom); end
      if (inject && k == 5) begin start = 1; a = 16'd2; b = 16'd2; end
      if (inject && k == 6) start = 0;
      if (busy) busy_cyc++;
      if (done) begin found = 1; p = product; lat = k; end
    end
    if (!found) chk("done_timeout", 32'(found), 32'd1);
    if (inject && found) begin
      start = 1; a = 16'd2; b = 16'd2;
      @(negedge clk);
      start = 0;
      chk("inject_dropped_busy", 32'(busy), 32'd0);
      chk("inject_product_held", product, p);
    end
  endtask

  task automatic wait_done(output logic [31:0] p, output int stamp);
    bit found = 0;
    p = '0; stamp = 0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk);
      if (done) begin found = 1; p = product; stamp = cyc; end
    end
    if (!found) chk("wait_done_timeout", 32'(found), 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] p, p2;
    int lat, bc, t1, t2;
    logic [15:0] ra, rb;
    bit saw_done;

    rst = 1; start = 0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 0;
    chk_en = 1;
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_product", product, 32'd0);

    // done lands in the 17th cycle after the start cycle; busy for 17 cycles
    run_op(16'd3, 16'd5, 0, p, lat, bc);
    chk("p_3x5", p, 32'h0000000F);
    chk("lat_3x5", 32'(lat), 32'd17);
    chk("busy_3x5", 32'(bc), 32'd17);

    run_op(16'hFFFF, 16'hFFFF, 0, p, lat, bc);
    chk("p_ffff", p, 32'hFFFE0001);
    run_op(16'h8000, 16'h0002, 0, p, lat, bc);
    chk("p_8000x2", p, 32'h00010000);
    run_op(16'h0000, 16'h1234, 0, p, lat, bc);
    chk("p_0xb", p, 32'd0);
    chk("lat_0xb", 32'(lat), 32'd17);
    run_op(16'h1234, 16'h0000, 0, p, lat, bc);
    chk("p_ax0", p, 32'd0);
    chk("lat_ax0", 32'(lat), 32'd17);

    run_op(16'd7, 16'd9, 1, p, lat, bc);
    chk("p_7x9_inject", p, 32'd63);
    run_op(16'd2, 16'd2, 0, p, lat, bc);
    chk("p_2x2", p, 32'd4);

    // reset in CALC cycle 8 aborts without done
    wait_ready();
    start = 1; a = 16'd100; b = 16'd200;
    saw_done = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) start = 0;
      if (done) saw_done = 1;
    end
    rst = 1;
    @(negedge clk);
    rst = 0;
    if (done) saw_done = 1;
    chk("abort_no_done", 32'(saw_done), 32'd0);
    chk("abort_product", product, 32'd0);
    chk("abort_ready", 32'(ready), 32'd1);
    run_op(16'd100, 16'd200, 0, p, lat, bc);
    chk("p_100x200", p, 32'h00004E20);

    // start held high: back-to-back operations, 18 cycles apart
    wait_ready();
    start = 1; a = 16'd10; b = 16'd10;
    wait_done(p, t1);
    a = 16'd11; b = 16'd11;
    wait_done(p2, t2);
    start = 0;
    chk("b2b_first", p, 32'd100);
    chk("b2b_second", p2, 32'd121);
    chk("b2b_interval", 32'(t2 - t1), 32'd18);

    for (int n = 0; n < 40; n++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      case ($urandom_range(0, 3))
        0: begin ra = 16'($urandom); rb = 16'($urandom); end
        1: begin ra = 16'hFFFF; rb = 16'($urandom); end
        2: begin ra = 16'($urandom); rb = 16'hFFFF; end
        default: begin ra = 16'($urandom_range(0, 15)); rb = 16'($urandom); end
      endcase
      run_op(ra, rb, bit'($urandom_range(0, 1)), p, lat, bc);
      chk("rand_prod", p, 32'(ra) * 32'(rb));
      chk("rand_lat", 32'(lat), 32'd17);
    end

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
